// File: rtl/uart_out_port.sv
// uart_out_port: buffers 16-bit output-port writes from the core in a FIFO and
// sends each word on a UART TX line as two 8N1 frames, low byte first.
module uart_out_port #(
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = 174
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     out_en,
   input  logic [15:0]              out_dat,
   output logic                     tx,
   output logic                     busy,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // Transmitter state
   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic          byte_sel;
   logic [15:0]   hold;

   // Per-cycle decisions
   logic          bit_done;
   logic          word_done;
   logic          pop;
   logic          push;
   logic          drop;
   logic [7:0]    cur_byte;
   logic [2:0]    next_idx;

   assign level = count;
   assign empty = (count == '0);
   assign full  = (count == COUNT_FULL);

   // Decide pop/push/drop for this edge and pick the byte currently on the line.
   // NOTE: every signal gets a default first so no path through always_comb infers a latch.
   always_comb begin
      bit_done  = 1'b0;
      word_done = 1'b0;
      pop       = 1'b0;
      push      = 1'b0;
      drop      = 1'b0;
      cur_byte  = hold[7:0];
      next_idx  = bit_idx + 3'd1;

      bit_done  = (baud_cnt == BAUD_LAST);
      word_done = (state == STOP) && bit_done && byte_sel;
      // A pop happens from IDLE, or straight out of the final stop bit so words go back to back.
      pop       = !empty && ((state == IDLE) || word_done);
      // A full FIFO still accepts a word when a pop frees a slot on the same edge.
      push      = out_en && (!full || pop);
      drop      = out_en && full && !pop;
      if (byte_sel) begin
         cur_byte = hold[15:8];
      end
   end

   // FIFO storage write; contents need no reset because pointers and count define validity.
   // NOTE: the memory array is deliberately left out of reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= out_dat;
      end
   end

   // FIFO pointers, occupancy count and sticky overflow flag.
   // NOTE: clocked blocks use <= so every register sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // UART framing FSM: START, 8 data bits LSB first, STOP, twice per word; tx and busy registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_sel <= 1'b0;
         hold     <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (pop) begin
                  hold     <= mem[rd_ptr];
                  byte_sel <= 1'b0;
                  state    <= START;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            START: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  tx       <= cur_byte[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= next_idx;
                     tx      <= cur_byte[next_idx];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            STOP: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (!byte_sel) begin
                     // Low byte done: send the high byte of the same word.
                     byte_sel <= 1'b1;
                     state    <= START;
                     tx       <= 1'b0;
                  end else if (pop) begin
                     // Word done and more queued: next start bit with no idle gap.
                     hold     <= mem[rd_ptr];
                     byte_sel <= 1'b0;
                     state    <= START;
                     tx       <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     tx    <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_out_port.sv
// tb_uart_out_port: directed and random stimulus for uart_out_port, checked every
// cycle against a word-level timing model plus a bench-side UART frame decoder.
module tb_uart_out_port;

   localparam int DEPTH     = 4;
   localparam int CPB       = 4;
   localparam int FRAME     = 10 * CPB;
   localparam int WORD_CLKS = 20 * CPB;
   localparam int LW        = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          out_en = 1'b0;
   logic [15:0]   out_dat = 16'h0;
   logic          tx;
   logic          busy;
   logic          empty;
   logic          full;
   logic [LW-1:0] level;
   logic          overflow;

   always #5 clk = ~clk;

   uart_out_port #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .reset    (reset),
      .out_en   (out_en),
      .out_dat  (out_dat),
      .tx       (tx),
      .busy     (busy),
      .empty    (empty),
      .full     (full),
      .level    (level),
      .overflow (overflow)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: queued words, the word on the line and when it was popped.
   logic [15:0] mq[$];
   logic [15:0] exp_words[$];
   logic [15:0] cur_word = 16'h0;
   int          last_pop = -1000;
   bit          ovf = 1'b0;

   // Frame decoder results.
   logic [15:0] rx_words[$];
   int          start_q[$];
   int          m_err = 0;
   int          m_cnt = 0;
   bit          m_active = 1'b0;
   bit          m_half = 1'b0;
   logic [7:0]  m_byte = 8'h0;
   logic [7:0]  m_low = 8'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock edge: predict the outcome, drive inputs, wait, compare all outputs.
   task automatic tick(input bit en, input logic [15:0] dat, input bit rst);
      int         e;
      int         off;
      int         b;
      bit         pop_now;
      bit         accept;
      bit         exp_busy;
      bit         exp_tx;
      logic [7:0] byt;
      e       = cyc + 1;
      pop_now = 1'b0;
      accept  = 1'b0;
      reset   = rst;
      out_en  = en;
      out_dat = dat;
      if (rst) begin
         if ((e - 1 - last_pop) < WORD_CLKS && exp_words.size() > 0)
            void'(exp_words.pop_back());
         mq.delete();
         last_pop = -1000;
         ovf      = 1'b0;
      end else begin
         pop_now = (mq.size() > 0) && (e >= last_pop + WORD_CLKS);
         accept  = en && ((mq.size() < DEPTH) || pop_now);
         if (pop_now) begin
            cur_word = mq.pop_front();
            last_pop = e;
            exp_words.push_back(cur_word);
         end
         if (accept) mq.push_back(dat);
         else if (en) ovf = 1'b1;
      end
      off      = e - last_pop;
      exp_busy = (off >= 0) && (off < WORD_CLKS);
      exp_tx   = 1'b1;
      if (exp_busy) begin
         byt = (off >= FRAME) ? cur_word[15:8] : cur_word[7:0];
         b   = (off % FRAME) / CPB;
         if (b == 0) exp_tx = 1'b0;
         else if (b <= 8) exp_tx = byt[b-1];
      end
      @(posedge clk);
      #1;
      cyc = e;
      check($sformatf("tx@%0d", e), tx, exp_tx);
      check($sformatf("busy@%0d", e), busy, exp_busy);
      check($sformatf("level@%0d", e), level, mq.size());
      check($sformatf("empty@%0d", e), empty, mq.size() == 0);
      check($sformatf("full@%0d", e), full, mq.size() == DEPTH);
      check($sformatf("overflow@%0d", e), overflow, ovf);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0);
   endtask

   // Bench-side UART receiver sampling mid-bit on the falling clock edge.
   initial begin
      int k;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            m_active = 1'b0;
            m_half   = 1'b0;
         end else if (!m_active) begin
            if (tx === 1'b0) begin
               m_active = 1'b1;
               m_cnt    = 0;
               start_q.push_back(cyc);
            end
         end else begin
            m_cnt++;
            if (m_cnt % CPB == CPB / 2) begin
               k = m_cnt / CPB;
               if (k == 0) begin
                  if (tx !== 1'b0) m_err++;
               end else if (k <= 8) begin
                  m_byte[k-1] = tx;
               end else begin
                  if (tx !== 1'b1) m_err++;
                  if (!m_half) begin
                     m_low  = m_byte;
                     m_half = 1'b1;
                  end else begin
                     rx_words.push_back({m_byte, m_low});
                     m_half = 1'b0;
                  end
                  m_active = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      int idx;
      int n;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b1);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 1'b0);
      idle(2);

      // Single word 0xA55A: start bit the edge after capture, busy for 80 cycles.
      tick(1'b1, 16'hA55A, 1'b0);
      check("single_level_capture", level, 1);
      check("single_busy_capture", busy, 1'b0);
      tick(1'b0, 16'h0, 1'b0);
      check("single_tx_start", tx, 1'b0);
      check("single_busy_start", busy, 1'b1);
      check("single_level_pop", level, 0);
      idle(WORD_CLKS - 1);
      check("single_busy_last", busy, 1'b1);
      tick(1'b0, 16'h0, 1'b0);
      check("single_busy_fall", busy, 1'b0);
      check("single_tx_idle", tx, 1'b1);
      idle(5);

      // Back-to-back words with no idle gap.
      idx = start_q.size();
      tick(1'b1, 16'h0001, 1'b0);
      tick(1'b1, 16'hFFFF, 1'b0);
      check("b2b_level_peak", level, 1);
      idle(2 * WORD_CLKS + 10);
      check("b2b_frames", start_q.size() - idx, 4);
      if (start_q.size() >= idx + 3) begin
         check("b2b_gap_frame", start_q[idx+1] - start_q[idx], FRAME);
         check("b2b_gap_word", start_q[idx+2] - start_q[idx], WORD_CLKS);
      end

      // Overflow: six consecutive pushes from idle, the sixth is dropped.
      for (int i = 0; i < 5; i++) tick(1'b1, 16'h1000 + 16'(i), 1'b0);
      check("ovf_full_before", full, 1'b1);
      check("ovf_flag_before", overflow, 1'b0);
      tick(1'b1, 16'h1005, 1'b0);
      check("ovf_full", full, 1'b1);
      check("ovf_flag", overflow, 1'b1);
      idle(5 * WORD_CLKS + 10);
      check("ovf_sticky", overflow, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b1);
      check("ovf_cleared", overflow, 1'b0);

      // Push on the exact edge the final stop bit pops while the FIFO is full.
      for (int i = 0; i < 5; i++) tick(1'b1, 16'h2000 + 16'(i), 1'b0);
      for (int i = 0; i < 200 && (cyc + 1) != last_pop + WORD_CLKS; i++) tick(1'b0, 16'h0, 1'b0);
      tick(1'b1, 16'h2ABC, 1'b0);
      check("pp_overflow", overflow, 1'b0);
      check("pp_level", level, DEPTH);
      idle(5 * WORD_CLKS + 10);

      // Ten spaced words: pointers wrap more than twice.
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 16'h3000 + 16'(i * 257), 1'b0);
         idle(99);
      end
      idle(WORD_CLKS);
      check("wrap_empty", empty, 1'b1);

      // Reset in the middle of a frame with a word still queued.
      tick(1'b1, 16'hBEEF, 1'b0);
      tick(1'b1, 16'h1234, 1'b0);
      idle(10);
      tick(1'b0, 16'h0, 1'b1);
      check("midrst_tx", tx, 1'b1);
      check("midrst_level", level, 0);
      check("midrst_busy", busy, 1'b0);
      idle(5);

      // Random traffic, bursty enough to fill and overflow the FIFO.
      for (int i = 0; i < 1200; i++)
         tick($urandom_range(0, 15) == 0, 16'($urandom), 1'b0);
      idle(5 * WORD_CLKS + 20);

      // Decoded line traffic must match the words the model sent, in order.
      check("rx_framing_errors", m_err, 0);
      check("rx_count", rx_words.size(), exp_words.size());
      if (rx_words.size() > 0) check("rx_first_word", rx_words[0], 16'hA55A);
      n = (rx_words.size() < exp_words.size()) ? rx_words.size() : exp_words.size();
      for (int i = 0; i < n; i++)
         check($sformatf("rx_word[%0d]", i), rx_words[i], exp_words[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
